// File: rtl/bidir_bus_arbiter_pkg.sv
// bidir_bus_arbiter_pkg: FSM state encodings and pad direction constants shared by the arbiter files
package bidir_bus_arbiter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;
  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ = 1'b0;
endpackage

// File: rtl/bidir_bus_arbiter_if.sv
// bidir_bus_arbiter_if: requester bundle; req/req_dir/last toward the arbiter, registered gnt/bus_oe/bus_dir/busy/beat_cnt back
interface bidir_bus_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req, req_dir, last, gnt;
  logic bus_oe, bus_dir, busy;
  logic [7:0] beat_cnt;
  modport master (input req, req_dir, last, output gnt, bus_oe, bus_dir, busy, beat_cnt);
  modport slave (output req, req_dir, last, input gnt, bus_oe, bus_dir, busy, beat_cnt);
endinterface

// File: rtl/bidir_bus_arbiter_rr_pick.sv
// bidir_bus_arbiter_rr_pick: combinational round-robin picker; req/ptr in, idx = first set req at or after ptr (mod N), valid = any req
module bidir_bus_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      idx = req[j] ? j : idx;
    end
  end
endmodule

// File: rtl/bidir_bus_arbiter.sv
// bidir_bus_arbiter: round-robin owner control for a shared tristate bus; clk, rst, bus (master: req/req_dir/last in, gnt/bus_oe/bus_dir/busy/beat_cnt out)
module bidir_bus_arbiter
  import bidir_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TURN = 1,
  parameter int MAXHOLD = 8
) (
  input logic clk,
  input logic rst,
  bidir_bus_arbiter_if.master bus
);
  localparam int W = $clog2(NREQ);
  logic [1:0] state, tcnt;
  logic [W-1:0] owner, rr_ptr, win;
  logic win_v, beat, rel;
  logic [NREQ-1:0] gnt;
  logic bus_oe, bus_dir, busy;
  logic [7:0] beat_cnt;
  bidir_bus_arbiter_rr_pick #(.N(NREQ), .W(W)) u_pick (.req(bus.req), .ptr(rr_ptr), .idx(win), .valid(win_v));
  assign beat = bus.req[owner];
  // last and the hold limit collapse into a single release
  assign rel = !beat || bus.last[owner] || beat_cnt == 8'(MAXHOLD - 1);
  assign bus.gnt = gnt;
  assign bus.bus_oe = bus_oe;
  assign bus.bus_dir = bus_dir;
  assign bus.busy = busy;
  assign bus.beat_cnt = beat_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tcnt <= '0;
      owner <= '0;
      rr_ptr <= '0;
      gnt <= '0;
      bus_oe <= 1'b0;
      bus_dir <= DIR_READ;
      busy <= 1'b0;
      beat_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (win_v) begin
        state <= ST_GRANT;
        owner <= win;
        gnt <= NREQ'(1) << win;
        bus_dir <= bus.req_dir[win];
        bus_oe <= bus.req_dir[win] == DIR_WRITE;
        busy <= 1'b1;
        beat_cnt <= '0;
        rr_ptr <= win == W'(NREQ - 1) ? '0 : win + 1'b1;
      end
    end else if (state == ST_GRANT) begin
      if (beat && beat_cnt != 8'hff) beat_cnt <= beat_cnt + 1'b1;
      if (rel) begin
        gnt <= '0;
        bus_oe <= 1'b0;
        tcnt <= '0;
        state <= TURN > 0 ? ST_TURN : ST_IDLE;
        busy <= TURN > 0;
        bus_dir <= TURN > 0 ? bus_dir : DIR_READ;
      end
    end else if (state == ST_TURN && tcnt != 2'(TURN - 1)) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      state <= ST_IDLE;
      busy <= 1'b0;
      bus_dir <= DIR_READ;
    end
  end
endmodule
